// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback buffer.
package wb_pkg;

  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_buffer_if.sv
// Producer-side handshake, register-file write port and forwarding lookups of the writeback buffer.
interface writeback_buffer_if #(
  parameter int unsigned DEPTH = wb_pkg::DEFAULT_DEPTH
);
  import wb_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  ResultValid;
  logic                  ResultReady;
  logic [REG_ADDR_W-1:0] ResultAddr;
  logic [DATA_W-1:0]     ResultData;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0]     WriteData;
  logic [REG_ADDR_W-1:0] LookupAddr1;
  logic [REG_ADDR_W-1:0] LookupAddr2;
  logic                  FwdHit1;
  logic                  FwdHit2;
  logic [DATA_W-1:0]     FwdData1;
  logic [DATA_W-1:0]     FwdData2;
  logic [CNT_W-1:0]      Count;

  modport master (
    output ResultValid, ResultAddr, ResultData, LookupAddr1, LookupAddr2,
    input  ResultReady, RegWrite, WriteAddr, WriteData,
    input  FwdHit1, FwdHit2, FwdData1, FwdData2, Count
  );

  modport slave (
    input  ResultValid, ResultAddr, ResultData, LookupAddr1, LookupAddr2,
    output ResultReady, RegWrite, WriteAddr, WriteData,
    output FwdHit1, FwdHit2, FwdData1, FwdData2, Count
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending writes; entries[] exposes the contents oldest-first for searching.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output wb_entry_t              entries [DEPTH],
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries[i] = mem[rd_ptr + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer between result producers and the register file.
// Define WB_FORWARD_EN to build the pending-write forwarding search; otherwise FwdHit/FwdData are 0.
module writeback_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input logic               Clock,
  input logic               Reset,
  writeback_buffer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        push_entry;
  wb_entry_t        head;
  wb_entry_t        entries [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  wb_entry_t        out_q;
  logic             reg_write_q;

  assign bus.ResultReady = !Reset && !full;
  // Writes to r0 are accepted but dropped here.
  assign push       = bus.ResultValid && bus.ResultReady && (bus.ResultAddr != '0);
  assign pop        = !empty;
  assign push_entry = '{addr: bus.ResultAddr, data: bus.ResultData};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clock      (Clock),
    .Reset      (Reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .entries    (entries),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  // Output register feeding the register-file write port.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      reg_write_q <= 1'b0;
      out_q       <= '0;
    end else if (pop) begin
      reg_write_q <= 1'b1;
      out_q       <= head;
    end else begin
      reg_write_q <= 1'b0;
    end
  end

  assign bus.RegWrite  = reg_write_q;
  assign bus.WriteAddr = out_q.addr;
  assign bus.WriteData = out_q.data;
  assign bus.Count     = count;

`ifdef WB_FORWARD_EN
  // Scan oldest to newest so the newest matching write wins.
  function automatic logic [DATA_W:0] fwd_search(
    input logic [REG_ADDR_W-1:0] addr,
    input logic                  out_valid,
    input wb_entry_t             out_entry,
    input wb_entry_t             ents [DEPTH],
    input logic [CNT_W-1:0]      n
  );
    logic [DATA_W:0] res;
    res = '0;
    if (addr != '0) begin
      if (out_valid && (out_entry.addr == addr)) res = {1'b1, out_entry.data};
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < n) && (ents[i].addr == addr)) res = {1'b1, ents[i].data};
      end
    end
    return res;
  endfunction

  assign {bus.FwdHit1, bus.FwdData1} = fwd_search(bus.LookupAddr1, reg_write_q, out_q, entries, count);
  assign {bus.FwdHit2, bus.FwdData2} = fwd_search(bus.LookupAddr2, reg_write_q, out_q, entries, count);
`else
  logic unused_lookup;
  assign unused_lookup = ^{bus.LookupAddr1, bus.LookupAddr2};
  assign bus.FwdHit1  = 1'b0;
  assign bus.FwdHit2  = 1'b0;
  assign bus.FwdData1 = '0;
  assign bus.FwdData2 = '0;
`endif

endmodule
